// File: rtl/cam_capture_rgb444.sv
// OV7670 QQVGA RGB444 capture: assembles byte pairs into 12-bit pixels and
// writes them linearly into the frame buffer, flagging malformed frames.
module cam_capture_rgb444 #(
  parameter int unsigned AW    = 15,
  parameter int unsigned DW    = 12,
  parameter int unsigned IMG_W = 160,
  parameter int unsigned IMG_H = 120
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          frame_done,
  output logic          frame_err
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned PW   = $clog2(IMG_W + 2);
  localparam int unsigned LW   = $clog2(IMG_H + 2);

  typedef enum logic [1:0] {WAIT_VS, WAIT_START, CAPTURE} state_t;

  state_t          state_q, state_d;
  logic            vsync_q, vsync_qq, href_q, href_qq, en_q;
  logic [7:0]      data_q;
  logic            phase_q, phase_d;
  logic [3:0]      red_q, red_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [PW-1:0]   px_cnt_q, px_cnt_d;
  logic [LW-1:0]   line_cnt_q, line_cnt_d;
  logic            ovf_q, ovf_d, odd_q, odd_d, len_q, len_d;
  logic [AW-1:0]   addr_in_d;
  logic [DW-1:0]   data_in_d;
  logic            regwrite_d, frame_done_d, frame_err_d;
  logic            vs_rise, href_fall, line_odd, line_bad;
  logic [LW-1:0]   lines_total;

  // A line ending in the same cycle as vsync rises still has to be judged.
  assign vs_rise     = vsync_q & ~vsync_qq;
  assign href_fall   = href_qq & ~href_q;
  assign line_odd    = href_fall & phase_q;
  assign line_bad    = href_fall & (px_cnt_q != PW'(IMG_W));
  assign lines_total = line_cnt_q + LW'(href_fall);

  // Next-state, datapath and output logic
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    red_d        = red_q;
    addr_d       = addr_q;
    px_cnt_d     = px_cnt_q;
    line_cnt_d   = line_cnt_q;
    ovf_d        = ovf_q;
    odd_d        = odd_q;
    len_d        = len_q;
    addr_in_d    = addr_in;
    data_in_d    = data_in;
    regwrite_d   = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err;

    case (state_q)
      WAIT_VS: begin
        if (vsync_q) state_d = WAIT_START;
      end
      WAIT_START: begin
        if (!vsync_q) state_d = en_q ? CAPTURE : WAIT_VS;
      end
      CAPTURE: begin
        if (vs_rise) begin
          state_d      = WAIT_START;
          frame_done_d = 1'b1;
          frame_err_d  = ovf_q | odd_q | len_q | line_odd | line_bad | href_q |
                         (lines_total != LW'(IMG_H));
          phase_d      = 1'b0;
          addr_d       = '0;
          px_cnt_d     = '0;
          line_cnt_d   = '0;
          ovf_d        = 1'b0;
          odd_d        = 1'b0;
          len_d        = 1'b0;
        end else if (href_q) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            red_d = data_q[3:0];
          end else begin
            if (px_cnt_q != PW'(IMG_W + 1)) px_cnt_d = px_cnt_q + PW'(1);
            if (addr_q < AW'(NPIX)) begin
              regwrite_d = 1'b1;
              addr_in_d  = addr_q;
              data_in_d  = DW'({red_q, data_q});
              addr_d     = addr_q + AW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
        end else if (href_fall) begin
          phase_d  = 1'b0;
          px_cnt_d = '0;
          if (line_odd) odd_d = 1'b1;
          if (line_bad) len_d = 1'b1;
          if (line_cnt_q != LW'(IMG_H + 1)) line_cnt_d = line_cnt_q + LW'(1);
        end
      end
      default: state_d = WAIT_VS;
    endcase
  end

  // Input sampling stage, state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= WAIT_VS;
      vsync_q    <= 1'b0;
      vsync_qq   <= 1'b0;
      href_q     <= 1'b0;
      href_qq    <= 1'b0;
      en_q       <= 1'b0;
      data_q     <= '0;
      phase_q    <= 1'b0;
      red_q      <= '0;
      addr_q     <= '0;
      px_cnt_q   <= '0;
      line_cnt_q <= '0;
      ovf_q      <= 1'b0;
      odd_q      <= 1'b0;
      len_q      <= 1'b0;
      addr_in    <= '0;
      data_in    <= '0;
      regwrite   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= vsync;
      vsync_qq   <= vsync_q;
      href_q     <= href;
      href_qq    <= href_q;
      en_q       <= en;
      data_q     <= px_data;
      phase_q    <= phase_d;
      red_q      <= red_d;
      addr_q     <= addr_d;
      px_cnt_q   <= px_cnt_d;
      line_cnt_q <= line_cnt_d;
      ovf_q      <= ovf_d;
      odd_q      <= odd_d;
      len_q      <= len_d;
      addr_in    <= addr_in_d;
      data_in    <= data_in_d;
      regwrite   <= regwrite_d;
      frame_done <= frame_done_d;
      frame_err  <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// Bench for cam_capture_rgb444 on a reduced 16x12 frame; a frame-level
// reference model predicts every buffer write and the per-frame error flag.
module tb_cam_capture_rgb444;

  localparam int unsigned AW   = 15;
  localparam int unsigned DW   = 12;
  localparam int unsigned W    = 16;
  localparam int unsigned H    = 12;
  localparam int unsigned NPIX = W * H;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic [7:0]    px_data = 8'h00;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          regwrite, frame_done, frame_err;

  cam_capture_rgb444 #(.AW(AW), .DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .en(en), .vsync(vsync), .href(href),
    .px_data(px_data), .addr_in(addr_in), .data_in(data_in),
    .regwrite(regwrite), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    int pat;
    int nlines;
    int odd_line;
    bit en;
    int exp_writes;
    int exp_done;
    bit exp_err;
  } frame_vec_t;

  int n_chk = 0;
  int n_fail = 0;
  wr_t exp_q[$];
  int len_q[$];
  logic [7:0] byte_q[$];
  int wr_cnt, done_cnt;
  logic [AW-1:0] last_wa;
  logic [DW-1:0] last_wd;
  logic err_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every pulse must match the next predicted write
  always @(negedge clk) begin
    if (reset) begin
      if (regwrite) begin
        wr_cnt++;
        last_wa = addr_in;
        last_wd = data_in;
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", 32'(addr_in), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_addr", 32'(addr_in), 32'(e.a));
          check("write_data", 32'(data_in), 32'(e.d));
        end
      end
      if (frame_done) done_cnt++;
    end
  end

  task automatic build(input int pat, input int nlines, input int odd_line);
    int k = 0;
    len_q.delete();
    byte_q.delete();
    for (int l = 0; l < nlines; l++) begin
      int npx = (l == odd_line) ? int'(W) - 1 : int'(W);
      for (int p = 0; p < npx; p++) begin
        logic [11:0] v;
        v = 12'(k % 4096);
        if (pat == 0) begin
          byte_q.push_back(8'h0A);
          byte_q.push_back(8'hBC);
        end else begin
          byte_q.push_back({4'h0, v[11:8]});
          byte_q.push_back(v[7:0]);
        end
        k++;
      end
      if (l == odd_line) byte_q.push_back(8'hEE);
      len_q.push_back((l == odd_line) ? 2 * npx + 1 : 2 * npx);
    end
  endtask

  task automatic build_random();
    int nlines;
    int r;
    len_q.delete();
    byte_q.delete();
    r = int'($urandom_range(0, 3));
    nlines = (r == 0) ? int'(H) - 1 : (r == 3) ? int'(H) + 1 : int'(H);
    for (int l = 0; l < nlines; l++) begin
      int nb;
      r = int'($urandom_range(0, 7));
      nb = (r == 0) ? 2 * int'(W) - 1 : (r == 1) ? 2 * int'(W) + 2 :
           (r == 2) ? 2 * int'(W) - 2 : 2 * int'(W);
      for (int b = 0; b < nb; b++) byte_q.push_back(8'($urandom));
      len_q.push_back(nb);
    end
  endtask

  // Frame-level reference: pair bytes per line, fill addresses until full
  task automatic model(input int max_pairs, output logic err);
    int addr = 0;
    int pairs = 0;
    int idx = 0;
    bit ovf = 0, odd = 0, bad = 0;
    for (int l = 0; l < len_q.size(); l++) begin
      int npx = len_q[l] / 2;
      if (len_q[l] % 2 != 0) odd = 1;
      if (npx != int'(W)) bad = 1;
      for (int p = 0; p < npx; p++) begin
        logic [7:0] b0, b1;
        b0 = byte_q[idx];
        b1 = byte_q[idx + 1];
        idx += 2;
        if (max_pairs < 0 || pairs < max_pairs) begin
          if (addr < int'(NPIX)) begin
            exp_q.push_back('{AW'(addr), DW'({b0[3:0], b1})});
            addr++;
          end else begin
            ovf = 1;
          end
        end
        pairs++;
      end
      idx += len_q[l] % 2;
    end
    err = ovf | odd | bad | (len_q.size() != int'(H));
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    #1;
    check("rst_regwrite", 32'(regwrite), 32'd0);
    check("rst_addr_in", 32'(addr_in), 32'd0);
    check("rst_data_in", 32'(data_in), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drive(input bit en_v, input int rst_line, input int rst_byte);
    int idx = 0;
    @(negedge clk);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    en = en_v;
    repeat (4) @(negedge clk);
    for (int l = 0; l < len_q.size(); l++) begin
      href = 1'b1;
      for (int b = 0; b < len_q[l]; b++) begin
        if (l == rst_line && b == rst_byte) do_reset();
        px_data = byte_q[idx];
        idx++;
        @(negedge clk);
      end
      href = 1'b0;
      px_data = 8'h00;
      repeat (6) @(negedge clk);
    end
    vsync = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic run_frame(input string name, input bit en_v, input int exp_writes,
                           input int exp_done, input bit exp_err);
    wr_cnt = 0;
    done_cnt = 0;
    drive(en_v, -1, -1);
    check({name, "_writes"}, 32'(wr_cnt), 32'(exp_writes));
    check({name, "_done"}, 32'(done_cnt), 32'(exp_done));
    check({name, "_err"}, 32'(frame_err), 32'(exp_err));
    check({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_vec_t vec[6];
    logic merr;
    vec[0] = '{0, int'(H),     -1, 1'b1, int'(NPIX),     1, 1'b0};
    vec[1] = '{1, int'(H),     -1, 1'b1, int'(NPIX),     1, 1'b0};
    vec[2] = '{0, int'(H) + 1, -1, 1'b1, int'(NPIX),     1, 1'b1};
    vec[3] = '{1, int'(H),      3, 1'b1, int'(NPIX) - 1, 1, 1'b1};
    vec[4] = '{0, int'(H),     -1, 1'b0, 0,              0, 1'b1};
    vec[5] = '{0, int'(H),     -1, 1'b1, int'(NPIX),     1, 1'b0};

    #12;
    check("init_regwrite", 32'(regwrite), 32'd0);
    check("init_addr_in", 32'(addr_in), 32'd0);
    check("init_data_in", 32'(data_in), 32'd0);
    check("init_frame_done", 32'(frame_done), 32'd0);
    check("init_frame_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      build(vec[i].pat, vec[i].nlines, vec[i].odd_line);
      if (vec[i].en) model(-1, merr);
      run_frame($sformatf("vec%0d", i), vec[i].en, vec[i].exp_writes,
                vec[i].exp_done, vec[i].exp_err);
      if (i == 1) begin
        check("vec1_last_addr", 32'(last_wa), 32'(NPIX - 1));
        check("vec1_last_data", 32'(last_wd), 32'h0BF);
      end
    end
    err_hold = 1'b0;

    for (int i = 0; i < 20; i++) begin
      bit en_v;
      en_v = ($urandom_range(0, 4) != 0);
      build_random();
      exp_q.delete();
      if (en_v) begin
        model(-1, merr);
        err_hold = merr;
      end
      run_frame($sformatf("rand%0d", i), en_v, exp_q.size(), en_v ? 1 : 0, err_hold);
    end

    // Error frame first so the reset visibly clears frame_err
    build(0, int'(H) + 1, -1);
    model(-1, merr);
    run_frame("pre_reset", 1'b1, int'(NPIX), 1, 1'b1);

    // Reset mid-line 5 after six pixels of that line have been written
    build(0, int'(H), -1);
    model(5 * int'(W) + 6, merr);
    wr_cnt = 0;
    done_cnt = 0;
    drive(1'b1, 5, 13);
    check("rst_frame_writes", 32'(wr_cnt), 32'(5 * W + 6));
    check("rst_frame_done", 32'(done_cnt), 32'd0);
    check("rst_frame_leftover", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    build(1, int'(H), -1);
    model(-1, merr);
    run_frame("post_reset", 1'b1, int'(NPIX), 1, 1'b0);
    check("post_reset_last_addr", 32'(last_wa), 32'(NPIX - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_capture_rgb444.md
# cam_capture_rgb444

Camera-side writer for the dual-port frame buffer. Samples the OV7670 parallel bus (pixel clock, VSYNC, HREF, 8-bit data) configured for QQVGA RGB444. Assembles two bytes per pixel into 12-bit words and drives the buffer's write port (`addr_in`, `data_in`, `regwrite`) with a linear address 0..IMG_W*IMG_H-1. Never touches address IMG_W*IMG_H, which is the reserved black pixel.

## Interface
- `AW`, 15: write-address width; must satisfy 2**AW > IMG_W*IMG_H.
- `DW`, 12: pixel width; fixed RGB444.
- `IMG_W`, 160: pixels per line.
- `IMG_H`, 120: lines per frame.

Ports:
- `clk`  in  1: camera pixel clock (PCLK); all logic on rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `en`  in  1: capture enable; sampled only at frame start.
- `vsync`  in  1: camera VSYNC, high = vertical blanking.
- `href`  in  1: camera HREF, high = valid bytes on `px_data`.
- `px_data`  in  8: camera data byte.
- `addr_in`  out  AW: buffer write address.
- `data_in`  out  DW: pixel {R[3:0],G[3:0],B[3:0]}.
- `regwrite`  out  1: buffer write strobe, one cycle per pixel.
- `frame_done`  out  1: one-cycle pulse at end of a captured frame.
- `frame_err`  out  1: error status of the last completed frame, held until next `frame_done`.

## Operation
- FSM states: WAIT_VS (wait for `vsync`=1), WAIT_START (wait for `vsync` falling), CAPTURE.
- Reset (async, `reset`=0): state WAIT_VS; all outputs 0; address, line counter, pixel counter, byte phase, error accumulators cleared.
- WAIT_VS -> WAIT_START when `vsync`=1.
- WAIT_START -> CAPTURE when `vsync`=0 and `en`=1; if `en`=0 on the falling edge, return to WAIT_VS (frame skipped, buffer untouched).
- CAPTURE: each cycle with `href`=1 toggles byte phase. Phase 0 latches `px_data[3:0]` as R. Phase 1 forms {R, `px_data`} and issues a write.
- Writes only when address < IMG_W*IMG_H; otherwise drop pixel and set overflow error. Address increments by 1 after each issued write.
- `href` falling: byte phase forced to 0. An odd trailing byte sets the error. Pixel-per-line count != IMG_W sets the error. Line counter increments.
- CAPTURE -> WAIT_START on `vsync` rising. In that cycle: `frame_done`=1. `frame_err` <= OR of overflow, odd-byte, bad-line-length, and line count != IMG_H. Address, counters, and accumulators are cleared.
- `vsync` rising while `href`=1: frame terminates normally; the partial line counts as bad length.
- Reset mid-frame: no further writes. Capture resumes only after a complete `vsync` high->low, so no partial frame is written from mid-stream.

## Timing
- Inputs sampled by one register stage; all outputs registered.
- Pixel sampled at phase-1 edge N: `regwrite`=1, `addr_in`, `data_in` valid in cycle N+1.
- Pixels are back to back: `regwrite` at most every other cycle.
- `addr_in`/`data_in` hold their last value when `regwrite`=0.
- `frame_done` is asserted the cycle after registered `vsync` is seen rising; `frame_err` updates in that same cycle.
- Reset values: `addr_in`=0, `data_in`=0, `regwrite`=0, `frame_done`=0, `frame_err`=0.

## Test plan
- Full frame, `en`=1, 120 lines x 320 bytes, byte pairs (0x0A, 0xBC) -> 19200 writes, addresses 0..19199, each `data_in`=0xABC, `frame_done` once, `frame_err`=0.
- Second frame with pixel value = address mod 4096 -> last write addr 19199, data 0xAFF. `frame_done` asserted on the second `vsync` rise. Address never 19200.
- 121 lines of 160 pixels -> writes stop at 19199, remaining 160 pixels dropped, `frame_err`=1.
- One line with 319 bytes -> no write for the odd byte. Next line starts at byte phase 0 with correct data; `frame_err`=1.
- `en`=0 at `vsync` fall -> zero `regwrite` pulses for the whole frame, no `frame_done`. `en`=1 at the next fall -> normal capture.
- `reset` low for 3 cycles mid-line 50 -> outputs 0 immediately. No writes until after the next `vsync` high->low; the following frame writes from address 0 with `frame_err`=0.
